// File: rtl/gf163_digit_feeder.sv
// Digit-serial operand feeder for a GF(2^163) multiplier array.
// Streams the multiplier MSB-digit-first, then captures the reduced product.
module gf163_digit_feeder #(
   parameter int M      = 163,
   parameter int DIGITS = 32,
   parameter int NDIG   = 6,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [M-1:0]      a_in,
   input  logic [M-1:0]      b_in,
   output logic [M-1:0]      a_out,
   output logic [DIGITS-1:0] b_digit_out,
   output logic              digit_valid,
   output logic              digit_last,
   input  logic              digit_ready,
   input  logic [M-1:0]      result_in,
   output logic [M-1:0]      c_out,
   output logic              done
);

   localparam int W  = NDIG * DIGITS;
   localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      WAIT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [3:0]    lat_q, lat_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [M-1:0]  a_q, a_d;
   logic [M-1:0]  c_q, c_d;
   logic          last_dig;

   assign last_dig = (k_q == KW'(NDIG - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         lat_q   <= '0;
         sh_q    <= '0;
         a_q     <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         lat_q   <= lat_d;
         sh_q    <= sh_d;
         a_q     <= a_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      lat_d       = lat_q;
      sh_d        = sh_q;
      a_d         = a_q;
      c_d         = c_q;
      start_ready = 1'b0;
      digit_valid = 1'b0;
      digit_last  = 1'b0;
      b_digit_out = '0;
      done        = 1'b0;
      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               a_d     = a_in;
               sh_d    = W'(b_in);
               k_d     = '0;
               state_d = FEED;
            end
         end
         FEED: begin
            digit_valid = 1'b1;
            digit_last  = last_dig;
            // Top digit of the shift register is always the current one.
            b_digit_out = sh_q[W-1 -: DIGITS];
            if (digit_ready) begin
               sh_d = sh_q << DIGITS;
               if (last_dig) begin
                  lat_d   = 4'(LAT);
                  state_d = WAIT;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         WAIT: begin
            lat_d = lat_q - 4'd1;
            if (lat_q <= 4'd1) begin
               lat_d   = '0;
               c_d     = result_in;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign a_out = a_q;
   assign c_out = c_q;

endmodule
